ysyx_23060240_sram: RTL and testbench
=====================================

# ysyx_23060240_sram

AXI4-Lite responder (slave) holding a word-addressed on-chip memory with programmable response latency. Sits on the slave side of the IFU/LSU bus arbiter and services the single serialized transaction stream it issues. It stands in for main memory in simulation, and its latency knobs stress the initiators' handshake logic.

## Interface
- DEPTH_LOG2, 10: memory holds 2^DEPTH_LOG2 32-bit words.
- BASE_ADDR, 32'h80000000: byte address of word 0.
- READ_LAT, 2: cycles from AR handshake to rvalid; legal range 1..15.
- WRITE_LAT, 2: cycles from write collection complete to bvalid; legal range 1..15.
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  reset; one clock, asynchronous and active-high.
- araddr  in  32  read byte address.
- arvalid  in  1  read address valid.
- arready  out  1  read address ready.
- rdata  out  32  read data.
- rvalid  out  1  read data valid.
- rready  in  1  read data ready.
- awaddr  in  32  write byte address.
- awvalid  in  1  write address valid.
- awready  out  1  write address ready.
- wdata  in  32  write data, full word.
- wvalid  in  1  write data valid.
- wready  out  1  write data ready.
- bvalid  out  1  write response valid.
- bready  in  1  write response ready.

## Operation
- There is one outstanding transaction at a time. FSM states are IDLE, R_WAIT, R_RESP, W_COLLECT, W_WAIT and W_RESP.
- Word index = (addr - BASE_ADDR) >> 2, keeping the low DEPTH_LOG2 bits. The address is in range when (addr - BASE_ADDR) < 4*2^DEPTH_LOG2. addr[1:0] is ignored.
- Read path:
  - IDLE: arready=1. arvalid&arready latches araddr, loads the latency counter with READ_LAT, and moves to R_WAIT.
  - R_WAIT: the counter decrements each cycle. When it reaches 1, rdata is registered (mem[idx] if in range, else 32'h0) and the FSM moves to R_RESP.
  - R_RESP: rvalid=1 and rdata is held stable until rvalid&rready, then the FSM returns to IDLE.
- Write path:
  - IDLE with arvalid=0: awready=1 and wready=1. Either handshake moves the FSM to W_COLLECT, which records which beats have been taken.
  - W_COLLECT: the ready of each already-taken beat drops to 0; the other ready stays at 1. AW and W may arrive in the same cycle or in either order.
  - Same-cycle AW+W in IDLE goes directly to W_WAIT.
  - When both beats are held, the counter loads WRITE_LAT and the FSM moves to W_WAIT.
  - W_WAIT: when the counter reaches 1, mem[idx] is written with wdata if in range (out-of-range writes are dropped silently) and the FSM moves to W_RESP.
  - W_RESP: bvalid=1 until bvalid&bready, then the FSM returns to IDLE.
- Priority in IDLE: if arvalid and awvalid/wvalid are high together, the read wins. awready and wready are 0 in that cycle.
- No response codes; every transaction completes with OKAY semantics.
- Memory contents are not reset.

## Timing
- Reset values: arready=0, awready=0, wready=0, rvalid=0, bvalid=0, rdata=32'h0, FSM=IDLE, counters 0.
  - arready, awready and wready all rise in the first cycle after rst deasserts, because IDLE drives them.
- arready is a function of state only. awready and wready may depend combinationally on arvalid in IDLE. No output depends combinationally on rready or bready.
- Read latency: an AR handshake at edge N gives rvalid=1 in the cycle after edge N+READ_LAT-1, i.e. READ_LAT cycles after the handshake cycle.
- Write latency: with the last of AW/W accepted at edge N, bvalid=1 follows WRITE_LAT cycles later. The memory update and the bvalid rise happen on the same edge.
- Minimum back-to-back throughput, when ready/valid is held high: one read every READ_LAT+2 cycles.
- A read issued right after a write's B handshake returns the new data; there is no hazard because the write commits before bvalid.
- rst asserted mid-transaction: everything aborts immediately. rvalid and bvalid drop asynchronously, and a pending write is not committed if W_WAIT has not completed.

## Test plan
- Write then read, READ_LAT=WRITE_LAT=2:
  - Write 0x80000004 <- 32'hDEADBEEF, then read 0x80000004 -> rdata=32'hDEADBEEF.
  - rvalid rises 2 cycles after the AR handshake; bvalid rises 2 cycles after the W handshake.
- W before AW: wvalid asserted 3 cycles ahead of awvalid, addr 0x80000010, data 32'h12345678.
  - Required: wready drops after the W beat and awready stays high.
  - A single bvalid follows, and a later read of the same address returns 32'h12345678.
- Backpressure: rready held low 5 cycles after rvalid -> rvalid and rdata stay stable for all 5 cycles; one handshake only.
  - Same check for bvalid with bready low.
- Collision: arvalid and awvalid+wvalid raised in the same IDLE cycle -> read is served first (awready=0 that cycle), then the write completes.
- Out of range: write 0x7FFFFFFC <- 32'hFFFFFFFF -> bvalid still returned. A read of 0x7FFFFFFC returns 32'h0, and a read of 0x80000000 is unchanged.
- Reset mid-operation: assert rst during W_WAIT -> bvalid=0 immediately, and a read of the target address after reset shows the pre-write value; all readys rise again after reset.

Source files
------------

// File: rtl/ysyx_23060240_sram_if.sv
// rtl/ysyx_23060240_sram_if.sv - AXI4-Lite read/write channel bundle for the SRAM responder
interface ysyx_23060240_sram_if;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic        rvalid;
   logic        rready;
   logic [31:0] awaddr;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic        wvalid;
   logic        wready;
   logic        bvalid;
   logic        bready;

   modport master (
      output araddr, arvalid, rready, awaddr, awvalid, wdata, wvalid, bready,
      input  arready, rdata, rvalid, awready, wready, bvalid
   );

   modport slave (
      input  araddr, arvalid, rready, awaddr, awvalid, wdata, wvalid, bready,
      output arready, rdata, rvalid, awready, wready, bvalid
   );
endinterface

// File: rtl/ysyx_23060240_sram.sv
// rtl/ysyx_23060240_sram.sv - AXI4-Lite word memory responder with programmable latency
module ysyx_23060240_sram #(
   parameter int          DEPTH_LOG2 = 10,
   parameter logic [31:0] BASE_ADDR  = 32'h80000000,
   parameter int          READ_LAT   = 2,
   parameter int          WRITE_LAT  = 2
) (
   input logic                  clk,
   input logic                  rst,
   ysyx_23060240_sram_if.slave  bus
);

   typedef enum logic [2:0] {
      IDLE,
      R_WAIT,
      R_RESP,
      W_COLLECT,
      W_WAIT,
      W_RESP
   } state_t;

   localparam int          DEPTH  = 1 << DEPTH_LOG2;
   localparam logic [32:0] SPAN   = 33'(DEPTH) << 2;
   localparam logic [3:0]  R_LOAD = 4'(READ_LAT);
   localparam logic [3:0]  W_LOAD = 4'(WRITE_LAT);

   state_t      state;
   logic [3:0]  cnt;
   logic [31:0] addr;
   logic [31:0] wbuf;
   logic [31:0] rdata_q;
   logic        ar_rdy;
   logic        aw_open;
   logic        w_open;
   logic        aw_have;
   logic        w_have;
   logic        rvalid_q;
   logic        bvalid_q;

   logic [31:0] mem [DEPTH];

   logic [31:0]           off;
   logic                  in_range;
   logic [DEPTH_LOG2-1:0] idx;
   logic                  awready_c;
   logic                  wready_c;
   logic                  ar_hs;
   logic                  aw_hs;
   logic                  w_hs;
   logic                  commit;

   // Address decode of the latched transaction address; low two bits are ignored.
   assign off      = addr - BASE_ADDR;
   assign in_range = {1'b0, off} < SPAN;
   assign idx      = off[DEPTH_LOG2+1:2];

   // A pending read in IDLE masks the write readies so the read wins a collision.
   assign awready_c = aw_open & ~(ar_rdy & bus.arvalid);
   assign wready_c  = w_open  & ~(ar_rdy & bus.arvalid);

   assign ar_hs = ar_rdy    & bus.arvalid;
   assign aw_hs = awready_c & bus.awvalid;
   assign w_hs  = wready_c  & bus.wvalid;

   // The write lands on the same edge that raises bvalid.
   assign commit = (state == W_WAIT) && (cnt == 4'd1) && in_range && !rst;

   assign bus.arready = ar_rdy;
   assign bus.awready = awready_c;
   assign bus.wready  = wready_c;
   assign bus.rdata   = rdata_q;
   assign bus.rvalid  = rvalid_q;
   assign bus.bvalid  = bvalid_q;

   // Memory array write port; contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (commit) begin
         mem[idx] <= wbuf;
      end
   end

   // Transaction FSM with registered readies and responses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= 4'd0;
         addr     <= 32'h0;
         wbuf     <= 32'h0;
         rdata_q  <= 32'h0;
         ar_rdy   <= 1'b0;
         aw_open  <= 1'b0;
         w_open   <= 1'b0;
         aw_have  <= 1'b0;
         w_have   <= 1'b0;
         rvalid_q <= 1'b0;
         bvalid_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               ar_rdy  <= 1'b1;
               aw_open <= 1'b1;
               w_open  <= 1'b1;
               if (ar_hs) begin
                  addr    <= bus.araddr;
                  cnt     <= R_LOAD;
                  state   <= R_WAIT;
                  ar_rdy  <= 1'b0;
                  aw_open <= 1'b0;
                  w_open  <= 1'b0;
               end else if (aw_hs || w_hs) begin
                  ar_rdy <= 1'b0;
                  if (aw_hs) addr <= bus.awaddr;
                  if (w_hs)  wbuf <= bus.wdata;
                  if (aw_hs && w_hs) begin
                     cnt     <= W_LOAD;
                     state   <= W_WAIT;
                     aw_open <= 1'b0;
                     w_open  <= 1'b0;
                  end else begin
                     state   <= W_COLLECT;
                     aw_have <= aw_hs;
                     w_have  <= w_hs;
                     aw_open <= ~aw_hs;
                     w_open  <= ~w_hs;
                  end
               end
            end
            R_WAIT: begin
               if (cnt == 4'd1) begin
                  rdata_q  <= in_range ? mem[idx] : 32'h0;
                  rvalid_q <= 1'b1;
                  cnt      <= 4'd0;
                  state    <= R_RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            R_RESP: begin
               if (bus.rready) begin
                  rvalid_q <= 1'b0;
                  state    <= IDLE;
                  ar_rdy   <= 1'b1;
                  aw_open  <= 1'b1;
                  w_open   <= 1'b1;
               end
            end
            W_COLLECT: begin
               if (aw_hs) begin
                  addr    <= bus.awaddr;
                  aw_have <= 1'b1;
                  aw_open <= 1'b0;
               end
               if (w_hs) begin
                  wbuf   <= bus.wdata;
                  w_have <= 1'b1;
                  w_open <= 1'b0;
               end
               if ((aw_have || aw_hs) && (w_have || w_hs)) begin
                  cnt     <= W_LOAD;
                  state   <= W_WAIT;
                  aw_have <= 1'b0;
                  w_have  <= 1'b0;
               end
            end
            W_WAIT: begin
               if (cnt == 4'd1) begin
                  bvalid_q <= 1'b1;
                  cnt      <= 4'd0;
                  state    <= W_RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            W_RESP: begin
               if (bus.bready) begin
                  bvalid_q <= 1'b0;
                  state    <= IDLE;
                  ar_rdy   <= 1'b1;
                  aw_open  <= 1'b1;
                  w_open   <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_23060240_sram.sv
// tb/tb_ysyx_23060240_sram.sv - directed vector bench for the SRAM responder
module tb_ysyx_23060240_sram;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ysyx_23060240_sram_if bus ();

   ysyx_23060240_sram dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
   } vec_t;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   function automatic logic sig(input int which);
      case (which)
         0:       return bus.rvalid;
         1:       return bus.bvalid;
         2:       return bus.arready;
         default: return bus.awready & bus.wready;
      endcase
   endfunction

   task automatic wait_for(input string name, input int which, output int n);
      n = 0;
      while (sig(which) !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: timeout after %0d cycles, want signal high", name, n);
      end
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, output int lat);
      int n;
      wait_for("write_ready", 3, n);
      bus.awaddr  = a;
      bus.wdata   = d;
      bus.awvalid = 1'b1;
      bus.wvalid  = 1'b1;
      bus.bready  = 1'b1;
      @(negedge clk);
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      wait_for("bvalid", 1, lat);
      @(negedge clk);
      chk("bvalid_drop", 32'(bus.bvalid), 32'h0);
      bus.bready = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] a, output logic [31:0] d, output int lat);
      int n;
      wait_for("arready", 2, n);
      bus.araddr  = a;
      bus.arvalid = 1'b1;
      bus.rready  = 1'b1;
      @(negedge clk);
      bus.arvalid = 1'b0;
      wait_for("rvalid", 0, lat);
      d = bus.rdata;
      @(negedge clk);
      chk("rvalid_drop", 32'(bus.rvalid), 32'h0);
      bus.rready = 1'b0;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        tbl[11];
      logic [31:0] d;
      int          lat;
      int          n;

      tbl[0]  = '{1'b1, 32'h80000004, 32'hDEADBEEF};
      tbl[1]  = '{1'b0, 32'h80000004, 32'hDEADBEEF};
      tbl[2]  = '{1'b1, 32'h80000000, 32'h11111111};
      tbl[3]  = '{1'b1, 32'h80000FFC, 32'hCAFEF00D};
      tbl[4]  = '{1'b1, 32'h80001000, 32'h55555555};
      tbl[5]  = '{1'b1, 32'h7FFFFFFC, 32'hFFFFFFFF};
      tbl[6]  = '{1'b0, 32'h80000FFC, 32'hCAFEF00D};
      tbl[7]  = '{1'b0, 32'h80001000, 32'h00000000};
      tbl[8]  = '{1'b0, 32'h7FFFFFFC, 32'h00000000};
      tbl[9]  = '{1'b0, 32'h80000000, 32'h11111111};
      tbl[10] = '{1'b0, 32'h80000006, 32'hDEADBEEF};

      rst = 1'b1;
      bus.araddr = 32'h0; bus.arvalid = 1'b0; bus.rready = 1'b0;
      bus.awaddr = 32'h0; bus.awvalid = 1'b0; bus.wdata  = 32'h0;
      bus.wvalid = 1'b0;  bus.bready  = 1'b0;

      // reset values
      repeat (2) @(negedge clk);
      chk("rst_arready", 32'(bus.arready), 32'h0);
      chk("rst_awready", 32'(bus.awready), 32'h0);
      chk("rst_wready",  32'(bus.wready),  32'h0);
      chk("rst_rvalid",  32'(bus.rvalid),  32'h0);
      chk("rst_bvalid",  32'(bus.bvalid),  32'h0);
      chk("rst_rdata",   bus.rdata,        32'h0);
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_arready", 32'(bus.arready), 32'h1);
      chk("post_rst_awready", 32'(bus.awready), 32'h1);
      chk("post_rst_wready",  32'(bus.wready),  32'h1);

      // table-driven writes and reads
      for (int i = 0; i < 11; i++) begin
         if (tbl[i].wr) begin
            do_write(tbl[i].addr, tbl[i].data, lat);
            chk($sformatf("vec%0d_wlat", i), 32'(lat), 32'd2);
         end else begin
            do_read(tbl[i].addr, d, lat);
            chk($sformatf("vec%0d_rdata", i), d, tbl[i].data);
            chk($sformatf("vec%0d_rlat", i), 32'(lat), 32'd2);
         end
      end

      // W beat three cycles ahead of AW, then B backpressure
      bus.wdata  = 32'h12345678;
      bus.wvalid = 1'b1;
      bus.bready = 1'b0;
      @(negedge clk);
      bus.wvalid = 1'b0;
      chk("wfirst_wready", 32'(bus.wready), 32'h0);
      chk("wfirst_awready", 32'(bus.awready), 32'h1);
      repeat (2) @(negedge clk);
      chk("wfirst_wready_hold", 32'(bus.wready), 32'h0);
      chk("wfirst_awready_hold", 32'(bus.awready), 32'h1);
      chk("wfirst_no_bvalid", 32'(bus.bvalid), 32'h0);
      bus.awaddr  = 32'h80000010;
      bus.awvalid = 1'b1;
      @(negedge clk);
      bus.awvalid = 1'b0;
      chk("wfirst_awready_drop", 32'(bus.awready), 32'h0);
      wait_for("wfirst_bvalid", 1, lat);
      chk("wfirst_wlat", 32'(lat), 32'd2);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk($sformatf("bstall%0d_bvalid", k), 32'(bus.bvalid), 32'h1);
      end
      bus.bready = 1'b1;
      @(negedge clk);
      bus.bready = 1'b0;
      chk("bstall_release", 32'(bus.bvalid), 32'h0);
      repeat (3) @(negedge clk);
      chk("bstall_single", 32'(bus.bvalid), 32'h0);
      do_read(32'h80000010, d, lat);
      chk("wfirst_readback", d, 32'h12345678);

      // R backpressure
      wait_for("rstall_arready", 2, n);
      bus.araddr  = 32'h80000004;
      bus.arvalid = 1'b1;
      bus.rready  = 1'b0;
      @(negedge clk);
      bus.arvalid = 1'b0;
      wait_for("rstall_rvalid", 0, lat);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk($sformatf("rstall%0d_rvalid", k), 32'(bus.rvalid), 32'h1);
         chk($sformatf("rstall%0d_rdata", k), bus.rdata, 32'hDEADBEEF);
      end
      bus.rready = 1'b1;
      @(negedge clk);
      bus.rready = 1'b0;
      chk("rstall_release", 32'(bus.rvalid), 32'h0);
      chk("rstall_arready", 32'(bus.arready), 32'h1);

      // AR collides with AW+W in IDLE: read first, then the write
      bus.araddr  = 32'h80000004;
      bus.arvalid = 1'b1;
      bus.awaddr  = 32'h80000020;
      bus.wdata   = 32'hA5A5A5A5;
      bus.awvalid = 1'b1;
      bus.wvalid  = 1'b1;
      bus.rready  = 1'b1;
      bus.bready  = 1'b1;
      #1;
      chk("coll_awready", 32'(bus.awready), 32'h0);
      chk("coll_wready",  32'(bus.wready),  32'h0);
      chk("coll_arready", 32'(bus.arready), 32'h1);
      @(negedge clk);
      bus.arvalid = 1'b0;
      wait_for("coll_rvalid", 0, lat);
      chk("coll_rdata", bus.rdata, 32'hDEADBEEF);
      chk("coll_no_bvalid", 32'(bus.bvalid), 32'h0);
      @(negedge clk);
      bus.rready = 1'b0;
      wait_for("coll_wready_up", 3, n);
      @(negedge clk);
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      wait_for("coll_bvalid", 1, lat);
      chk("coll_wlat", 32'(lat), 32'd2);
      @(negedge clk);
      bus.bready = 1'b0;
      do_read(32'h80000020, d, lat);
      chk("coll_readback", d, 32'hA5A5A5A5);

      // reset during W_WAIT aborts the write
      wait_for("abort_ready", 3, n);
      bus.awaddr  = 32'h80000004;
      bus.wdata   = 32'h0BADF00D;
      bus.awvalid = 1'b1;
      bus.wvalid  = 1'b1;
      bus.bready  = 1'b1;
      @(negedge clk);
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      rst = 1'b1;
      #1;
      chk("abort_bvalid", 32'(bus.bvalid), 32'h0);
      @(negedge clk);
      chk("abort_arready_in_rst", 32'(bus.arready), 32'h0);
      rst = 1'b0;
      @(negedge clk);
      chk("abort_arready", 32'(bus.arready), 32'h1);
      chk("abort_awready", 32'(bus.awready), 32'h1);
      chk("abort_wready",  32'(bus.wready),  32'h1);
      @(negedge clk);
      chk("abort_no_bvalid", 32'(bus.bvalid), 32'h0);
      bus.bready = 1'b0;
      do_read(32'h80000004, d, lat);
      chk("abort_readback", d, 32'hDEADBEEF);

      // reset while bvalid is pending drops it asynchronously
      wait_for("bdrop_ready", 3, n);
      bus.awaddr  = 32'h80000040;
      bus.wdata   = 32'h77777777;
      bus.awvalid = 1'b1;
      bus.wvalid  = 1'b1;
      bus.bready  = 1'b0;
      @(negedge clk);
      bus.awvalid = 1'b0;
      bus.wvalid  = 1'b0;
      wait_for("bdrop_bvalid", 1, lat);
      rst = 1'b1;
      #1;
      chk("bdrop_async", 32'(bus.bvalid), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      do_read(32'h80000040, d, lat);
      chk("bdrop_committed", d, 32'h77777777);

      // reset while rvalid is pending drops it asynchronously
      wait_for("rdrop_arready", 2, n);
      bus.araddr  = 32'h80000040;
      bus.arvalid = 1'b1;
      bus.rready  = 1'b0;
      @(negedge clk);
      bus.arvalid = 1'b0;
      wait_for("rdrop_rvalid", 0, lat);
      rst = 1'b1;
      #1;
      chk("rdrop_async", 32'(bus.rvalid), 32'h0);
      chk("rdrop_rdata", bus.rdata, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
